btn_event_sched: RTL and testbench

BTN_EVENT_SCHED -- requirements
Module: btn_event_sched

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_event_sched_if.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/btn_event_sched.sv | 107 ++++++++++
 tb/tb_btn_event_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants, width helpers and FSM encoding for the button event scheduler.
package btn_pkg;

    localparam int unsigned N_BTN_DEF   = 4;
    localparam int unsigned HOLDOFF_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter must be able to hold HOLDOFF itself, hence +1.
    function automatic int unsigned cnt_width(input int unsigned h);
        return (h > 0) ? $clog2(h + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_event_sched_if.sv
// Valid/ready event channel carrying the channel index of a button press.
interface btn_event_sched_if #(
    parameter int unsigned N_BTN = btn_pkg::N_BTN_DEF
);
    localparam int unsigned ID_W = btn_pkg::id_width(N_BTN);

    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;

    modport master (output ev_valid, output ev_id, input ev_ready);
    modport slave  (input ev_valid, input ev_id, output ev_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request found scanning upward from last_grant+1.
module rr_arbiter
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN = N_BTN_DEF
) (
    input  logic [N_BTN-1:0]           req,
    input  logic [id_width(N_BTN)-1:0] last_grant,
    output logic [id_width(N_BTN)-1:0] grant_id,
    output logic                       any
);
    localparam int unsigned ID_W = id_width(N_BTN);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= N_BTN; k++) begin
            idx = ID_W'((32'(last_grant) + k) % N_BTN);
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/btn_event_sched.sv
// Collects one-cycle button pulses into pending bits and offers them one at a time,
// round-robin, over a valid/ready channel with a per-channel post-grant holdoff.
module btn_event_sched
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN   = N_BTN_DEF,
    parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  pulse_in,
    btn_event_sched_if.master ev,
    output logic [N_BTN-1:0]  ev_dropped,
    input  logic              clr_drop,
    output logic              busy
);
    localparam int unsigned ID_W  = id_width(N_BTN);
    localparam int unsigned CNT_W = cnt_width(HOLDOFF);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  grant_id;
    logic             any_req;
    logic             accept;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] dropped_q;
    logic [N_BTN-1:0] hold_vec, acc_vec, live;
    logic [CNT_W-1:0] hold_cnt_q [N_BTN];

    rr_arbiter #(.N_BTN(N_BTN)) u_arb (
        .req       (pending_q),
        .last_grant(last_grant_q),
        .grant_id  (grant_id),
        .any       (any_req)
    );

    assign accept = (state_q == OFFER) && ev.ev_ready;

    // A pulse counts only outside holdoff; the accepting channel's pulse is masked too.
    always_comb begin
        acc_vec  = '0;
        hold_vec = '0;
        if (accept) acc_vec[id_q] = 1'b1;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            hold_vec[i] = (hold_cnt_q[i] != '0);
        end
        live      = pulse_in & ~hold_vec & ~acc_vec;
        pending_d = (pending_q | live) & ~acc_vec;
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OFFER;
                    id_d    = grant_id;
                end
            end
            OFFER: begin
                if (ev.ev_ready) begin
                    state_d      = IDLE;
                    id_d         = '0;
                    last_grant_d = id_q;
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_BTN - 1);
            pending_q    <= '0;
            dropped_q    <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                hold_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            // A fresh drop in the clearing cycle survives the clear.
            if (clr_drop) dropped_q <= live & pending_q;
            else          dropped_q <= dropped_q | (live & pending_q);
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (acc_vec[i])                 hold_cnt_q[i] <= CNT_W'(HOLDOFF);
                else if (hold_cnt_q[i] != '0)   hold_cnt_q[i] <= hold_cnt_q[i] - CNT_W'(1);
            end
        end
    end

    assign ev.ev_valid = (state_q == OFFER);
    assign ev.ev_id    = id_q;
    assign ev_dropped  = dropped_q;
    assign busy        = (|pending_q) || (state_q == OFFER);

endmodule

// File: tb/tb_btn_event_sched.sv
// Randomized and directed bench for btn_event_sched with a behavioural model and event scoreboard.
module tb_btn_event_sched;
    import btn_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned HO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr_drop;
    logic [N-1:0] pulse_in;
    logic [N-1:0] ev_dropped;
    logic         busy;

    btn_event_sched_if #(.N_BTN(N)) ev ();

    btn_event_sched #(.N_BTN(N), .HOLDOFF(HO)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .ev        (ev),
        .ev_dropped(ev_dropped),
        .clr_drop  (clr_drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending set, holdoff timers, drop flags and the event being offered.
    bit m_init = 1'b0;
    bit m_pend [N];
    int m_hold [N];
    bit m_drop [N];
    int m_lg;
    bit m_off;
    int m_id;
    int exp_q [$];

    function automatic logic [N-1:0] model_drops();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = m_drop[c];
        return r;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = m_off;
        for (int c = 0; c < N; c++) b = b | m_pend[c];
        return b;
    endfunction

    always @(posedge clk) begin
        int acc;
        int win;
        bit found;
        bit nd [N];
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_pend[c] = 1'b0; m_hold[c] = 0; m_drop[c] = 1'b0;
            end
            m_lg   = N - 1;
            m_off  = 1'b0;
            m_id   = 0;
            exp_q.delete();
            m_init = 1'b1;
        end else if (m_init) begin
            acc   = (m_off && ev.ev_ready) ? m_id : -1;
            found = 1'b0;
            win   = 0;
            if (!m_off) begin
                for (int k = 1; k <= N; k++) begin
                    if (!found && m_pend[(m_lg + k) % N]) begin
                        found = 1'b1;
                        win   = (m_lg + k) % N;
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                nd[c] = 1'b0;
                if (c == acc) begin
                    m_pend[c] = 1'b0;
                    m_hold[c] = HO;
                end else begin
                    if (pulse_in[c] && m_hold[c] == 0) begin
                        if (m_pend[c]) nd[c] = 1'b1;
                        else           m_pend[c] = 1'b1;
                    end
                    if (m_hold[c] > 0) m_hold[c]--;
                end
                m_drop[c] = (clr_drop ? 1'b0 : m_drop[c]) | nd[c];
            end
            if (acc >= 0) begin
                m_off = 1'b0;
                m_lg  = acc;
            end else if (found) begin
                m_off = 1'b1;
                m_id  = win;
                exp_q.push_back(win);
            end
        end
    end

    // Monitor: compares visible state each cycle and pops the scoreboard on every handshake.
    always @(negedge clk) begin
        int e;
        if (m_init) begin
            chk("mon_valid", 32'(ev.ev_valid), 32'(m_off));
            chk("mon_id", 32'(ev.ev_id), m_off ? 32'(m_id) : 32'd0);
            chk("mon_dropped", 32'(ev_dropped), 32'(model_drops()));
            chk("mon_busy", 32'(busy), 32'(model_busy()));
            if (!rst && ev.ev_valid && ev.ev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_event", 32'(ev.ev_id), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_event_id", 32'(ev.ev_id), 32'(e));
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] p, input logic r, input logic c);
        pulse_in    = p;
        ev.ev_ready = r;
        clr_drop    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc('0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        pulse_in    = '0;
        ev.ev_ready = 1'b0;
        clr_drop    = 1'b0;
        do_reset();
        chk("rst_valid", 32'(ev.ev_valid), 32'd0);
        chk("rst_id", 32'(ev.ev_id), 32'd0);
        chk("rst_dropped", 32'(ev_dropped), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single press: valid exactly two cycles after the pulse, busy gone one later.
        cyc(4'b0001, 1'b1, 1'b0);
        chk("single_n1_valid", 32'(ev.ev_valid), 32'd0);
        chk("single_n1_busy", 32'(busy), 32'd1);
        cyc('0, 1'b1, 1'b0);
        chk("single_n2_valid", 32'(ev.ev_valid), 32'd1);
        chk("single_n2_id", 32'(ev.ev_id), 32'd0);
        cyc('0, 1'b1, 1'b0);
        chk("single_n3_valid", 32'(ev.ev_valid), 32'd0);
        chk("single_n3_busy", 32'(busy), 32'd0);

        // All four at once from reset priority: 0,1,2,3 every other cycle.
        do_reset();
        cyc(4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            cyc('0, 1'b1, 1'b0);
            chk("rr_valid", 32'(ev.ev_valid), 32'd1);
            chk("rr_id", 32'(ev.ev_id), 32'(k));
            cyc('0, 1'b1, 1'b0);
            chk("rr_gap", 32'(ev.ev_valid), 32'd0);
        end
        chk("rr_no_drop", 32'(ev_dropped), 32'd0);

        // Backpressure with a second press on the offered channel.
        idle(20);
        cyc(4'b0100, 1'b0, 1'b0);
        repeat (3) cyc('0, 1'b0, 1'b0);
        cyc(4'b0100, 1'b0, 1'b0);
        repeat (5) cyc('0, 1'b0, 1'b0);
        chk("bp_valid", 32'(ev.ev_valid), 32'd1);
        chk("bp_id", 32'(ev.ev_id), 32'd2);
        chk("bp_dropped", 32'(ev_dropped), 32'b0100);
        cyc('0, 1'b1, 1'b0);
        idle(2);
        chk("bp_single_event", 32'(ev.ev_valid), 32'd0);
        chk("bp_busy", 32'(busy), 32'd0);

        // Clear racing a new drop on channel 3.
        idle(20);
        cyc(4'b1000, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        chk("race_drop_set", 32'(ev_dropped), 32'b1000);
        cyc(4'b1000, 1'b0, 1'b1);
        chk("race_drop_wins", 32'(ev_dropped), 32'b1000);
        cyc('0, 1'b0, 1'b1);
        chk("race_cleared", 32'(ev_dropped), 32'd0);

        // Holdoff: accept at t, press at t+5 ignored, press at t+20 delivered.
        cyc('0, 1'b1, 1'b0);
        repeat (4) cyc('0, 1'b1, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0);
        idle(2);
        chk("ho_ignored_valid", 32'(ev.ev_valid), 32'd0);
        chk("ho_ignored_busy", 32'(busy), 32'd0);
        chk("ho_ignored_drop", 32'(ev_dropped), 32'd0);
        idle(12);
        cyc(4'b1000, 1'b1, 1'b0);
        cyc('0, 1'b1, 1'b0);
        chk("ho_late_valid", 32'(ev.ev_valid), 32'd1);
        chk("ho_late_id", 32'(ev.ev_id), 32'd3);
        cyc('0, 1'b1, 1'b0);

        // Reset while offering channel 2.
        idle(20);
        cyc(4'b0100, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        chk("rmo_offer_id", 32'(ev.ev_id), 32'd2);
        rst = 1'b1;
        cyc(4'b0100, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rmo_valid", 32'(ev.ev_valid), 32'd0);
        chk("rmo_busy", 32'(busy), 32'd0);
        cyc(4'b1001, 1'b1, 1'b0);
        cyc('0, 1'b1, 1'b0);
        chk("rmo_ch0_first", 32'(ev.ev_id), 32'd0);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b1, 1'b0);
        chk("rmo_ch3_next", 32'(ev.ev_id), 32'd3);

        // Randomized traffic, backpressure, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] p;
            for (int b = 0; b < N; b++) p[b] = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 399) == 0);
            cyc(p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        rst = 1'b0;
        idle(40);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
